uart_rx_tx_fifo: RTL and testbench

Elastic byte buffer between the UART receiver (DV/byte strobe output) and the UART transmitter (DV/byte strobe input) in the loopback path.
- Absorbs back-to-back received bytes while the transmitter is busy.
- Launches one TX byte at a time; the next byte is not launched until TX reports done.
- Exposes fill level, empty/full, and a sticky overflow flag for status/seven-segment display logic.

---
 rtl/uart_rx_tx_fifo.sv | 136 +++++++++++++
 tb/tb_uart_rx_tx_fifo.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_tx_fifo.sv
// Elastic byte FIFO between the UART receiver and transmitter in the loopback path.
// Bytes strobed in on i_RX_DV are buffered and launched to the transmitter one at a time,
// waiting for i_TX_Done between launches. Status outputs give fill level, empty/full and a
// sticky overflow flag.
// Optional build macro UART_FIFO_CRLF_EN: after a launched 8'h0D the block inserts an
// 8'h0A into the TX stream without popping the FIFO.
module uart_rx_tx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic                  i_RX_DV,
    input  logic [7:0]            i_RX_Byte,
    input  logic                  i_TX_Active,
    input  logic                  i_TX_Done,
    output logic                  o_TX_DV,
    output logic [7:0]            o_TX_Byte,
    output logic [DEPTH_LOG2:0]   o_Count,
    output logic                  o_Empty,
    output logic                  o_Full,
    output logic                  o_Overflow,
    input  logic                  i_Clear_Ovf
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DepthCnt = (DEPTH_LOG2 + 1)'(Depth);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitStart,
        StWaitDone,
        StInsertLf
    } state_e;

    state_e                  state_q, state_d;
    logic [7:0]              mem_q [Depth];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic                    empty_q, full_q, ovf_q;
    logic                    tx_dv_q, tx_dv_d;
    logic [7:0]              tx_byte_q, tx_byte_d;
    logic                    push, pop, drop, lf_needed;

`ifdef UART_FIFO_CRLF_EN
    assign lf_needed = (tx_byte_q == 8'h0D);
`else
    assign lf_needed = 1'b0;
`endif

    // Push/pop decode: a pop in the LAUNCH cycle frees a slot for a same-cycle push when full.
    always_comb begin
        pop     = (state_q == StLaunch);
        push    = i_RX_DV && (!full_q || pop);
        drop    = i_RX_DV && full_q && !pop;
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // TX launch FSM: next state plus the registered strobe/byte loaded on entry to a launch.
    always_comb begin
        state_d   = state_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0 && !i_TX_Active) begin
                    state_d   = StLaunch;
                    tx_dv_d   = 1'b1;
                    tx_byte_d = mem_q[rd_ptr_q];
                end
            end
            StLaunch:   state_d = StWaitStart;
            // Done is checked first so a frame too short to show Active is not missed.
            StWaitStart, StWaitDone: begin
                if (i_TX_Done) begin
                    if (lf_needed) begin
                        state_d   = StInsertLf;
                        tx_dv_d   = 1'b1;
                        tx_byte_d = 8'h0A;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (state_q == StWaitStart && i_TX_Active) begin
                    state_d = StWaitDone;
                end
            end
            StInsertLf: state_d = StWaitStart;
            default:    state_d = StIdle;
        endcase
    end

    // Control/status registers with synchronous active-low reset.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            count_q   <= count_d;
            empty_q   <= (count_d == '0);
            full_q    <= (count_d == DepthCnt);
            if (push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            // Set wins over clear.
            if (drop)             ovf_q <= 1'b1;
            else if (i_Clear_Ovf) ovf_q <= 1'b0;
        end
    end

    // Byte storage; contents need no reset.
    always_ff @(posedge i_Clk) begin
        if (push) mem_q[wr_ptr_q] <= i_RX_Byte;
    end

    assign o_TX_DV    = tx_dv_q;
    assign o_TX_Byte  = tx_byte_q;
    assign o_Count    = count_q;
    assign o_Empty    = empty_q;
    assign o_Full     = full_q;
    assign o_Overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_tx_fifo.sv
// Self-checking bench for uart_rx_tx_fifo: directed steps, scoreboard of expected TX bytes,
// and a simple transmitter model that answers each o_TX_DV with an active window and done.
module tb_uart_rx_tx_fifo;

    logic       i_Clk = 1'b0;
    logic       i_Rst_L;
    logic       i_RX_DV;
    logic [7:0] i_RX_Byte;
    logic       i_TX_Active;
    logic       i_TX_Done;
    logic       o_TX_DV;
    logic [7:0] o_TX_Byte;
    logic [4:0] o_Count;
    logic       o_Empty;
    logic       o_Full;
    logic       o_Overflow;
    logic       i_Clear_Ovf;

    logic       tx_act;
    logic       tx_hold;
    int         busy_left;
    int         busy_len;
    int         dv_cnt;
    int         n_assert;
    int         n_fail;
    logic [7:0] sb[$];

    assign i_TX_Active = tx_act | tx_hold;

    uart_rx_tx_fifo #(.DEPTH_LOG2(4)) dut (
        .i_Clk       (i_Clk),
        .i_Rst_L     (i_Rst_L),
        .i_RX_DV     (i_RX_DV),
        .i_RX_Byte   (i_RX_Byte),
        .i_TX_Active (i_TX_Active),
        .i_TX_Done   (i_TX_Done),
        .o_TX_DV     (o_TX_DV),
        .o_TX_Byte   (o_TX_Byte),
        .o_Count     (o_Count),
        .o_Empty     (o_Empty),
        .o_Full      (o_Full),
        .o_Overflow  (o_Overflow),
        .i_Clear_Ovf (i_Clear_Ovf)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transmitter model plus scoreboard pop on every strobe.
    initial begin
        tx_act    = 1'b0;
        i_TX_Done = 1'b0;
        busy_left = 0;
        dv_cnt    = 0;
        forever begin
            @(negedge i_Clk);
            i_TX_Done = 1'b0;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    tx_act    = 1'b0;
                    i_TX_Done = 1'b1;
                end
            end
            if (o_TX_DV === 1'b1) begin
                dv_cnt++;
                chk("dv_while_tx_busy", {31'd0, tx_act}, 32'd0);
                chk("sb_has_entry", {31'd0, (sb.size() > 0)}, 32'd1);
                if (sb.size() > 0) chk("tx_byte", {24'd0, o_TX_Byte}, {24'd0, sb.pop_front()});
                tx_act    = 1'b1;
                busy_left = busy_len;
            end
        end
    end

    task automatic push_byte(input logic [7:0] b, input bit expect_kept);
        i_RX_DV   = 1'b1;
        i_RX_Byte = b;
        if (expect_kept) sb.push_back(b);
        @(negedge i_Clk);
        i_RX_DV = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (!(sb.size() == 0 && busy_left == 0 && !tx_act && !i_TX_Done && o_Empty)
               && n < budget) begin
            @(negedge i_Clk);
            n++;
        end
        chk("drain_within_budget", {31'd0, (n < budget)}, 32'd1);
        @(negedge i_Clk);
    endtask

    initial begin
        int         dv0;
        int         max_cnt;
        logic       any_full;
        n_assert    = 0;
        n_fail      = 0;
        busy_len    = 4;
        tx_hold     = 1'b0;
        i_Rst_L     = 1'b0;
        i_RX_DV     = 1'b0;
        i_RX_Byte   = 8'h00;
        i_Clear_Ovf = 1'b0;

        // Power-on reset.
        repeat (3) @(negedge i_Clk);
        chk("rst_tx_dv", {31'd0, o_TX_DV}, 32'd0);
        chk("rst_count", {27'd0, o_Count}, 32'd0);
        chk("rst_empty", {31'd0, o_Empty}, 32'd1);
        chk("rst_full", {31'd0, o_Full}, 32'd0);
        chk("rst_ovf", {31'd0, o_Overflow}, 32'd0);
        chk("rst_tx_byte", {24'd0, o_TX_Byte}, 32'd0);
        i_Rst_L = 1'b1;
        @(negedge i_Clk);

        // Single byte latency: DV in cycle c, not empty in c+1, launch in c+2.
        dv0 = dv_cnt;
        push_byte(8'hA5, 1'b1);
        chk("lat_c1_empty", {31'd0, o_Empty}, 32'd0);
        chk("lat_c1_count", {27'd0, o_Count}, 32'd1);
        chk("lat_c1_no_dv", {31'd0, o_TX_DV}, 32'd0);
        @(negedge i_Clk);
        chk("lat_c2_dv", {31'd0, o_TX_DV}, 32'd1);
        chk("lat_c2_byte", {24'd0, o_TX_Byte}, 32'hA5);
        @(negedge i_Clk);
        chk("lat_c3_dv_low", {31'd0, o_TX_DV}, 32'd0);
        chk("lat_c3_count", {27'd0, o_Count}, 32'd0);
        chk("lat_c3_byte_held", {24'd0, o_TX_Byte}, 32'hA5);
        wait_drain(100);
        chk("lat_dv_count", dv_cnt - dv0, 32'd1);

        // Burst of 16 with slow transmitter: first pop leaves at most 15 stored.
        busy_len = 2170;
        dv0      = dv_cnt;
        max_cnt  = 0;
        any_full = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (o_Full) any_full = 1'b1;
            if (int'(o_Count) > max_cnt) max_cnt = int'(o_Count);
            push_byte(8'(i), 1'b1);
        end
        if (o_Full) any_full = 1'b1;
        if (int'(o_Count) > max_cnt) max_cnt = int'(o_Count);
        chk("burst_never_full", {31'd0, any_full}, 32'd0);
        chk("burst_max_count", max_cnt, 32'd15);
        wait_drain(16 * 2180 + 200);
        chk("burst_dv_count", dv_cnt - dv0, 32'd16);

        // Overflow: 18 bytes while TX is held busy; last two dropped.
        busy_len = 4;
        tx_hold  = 1'b1;
        for (int i = 0; i < 18; i++) push_byte(8'h20 + 8'(i), i < 16);
        chk("ovf_count", {27'd0, o_Count}, 32'd16);
        chk("ovf_full", {31'd0, o_Full}, 32'd1);
        chk("ovf_flag", {31'd0, o_Overflow}, 32'd1);
        i_Clear_Ovf = 1'b1;
        @(negedge i_Clk);
        i_Clear_Ovf = 1'b0;
        chk("ovf_cleared", {31'd0, o_Overflow}, 32'd0);
        // Drop and clear in the same cycle: set wins.
        i_Clear_Ovf = 1'b1;
        push_byte(8'hEE, 1'b0);
        i_Clear_Ovf = 1'b0;
        chk("ovf_set_wins", {31'd0, o_Overflow}, 32'd1);
        chk("ovf_count_kept", {27'd0, o_Count}, 32'd16);
        i_Clear_Ovf = 1'b1;
        @(negedge i_Clk);
        i_Clear_Ovf = 1'b0;
        chk("ovf_cleared2", {31'd0, o_Overflow}, 32'd0);

        // Full FIFO with a push coinciding with the LAUNCH pop: accepted.
        dv0     = dv_cnt;
        tx_hold = 1'b0;
        @(negedge i_Clk);
        chk("full_launch_dv", {31'd0, o_TX_DV}, 32'd1);
        push_byte(8'h77, 1'b1);
        chk("full_launch_count", {27'd0, o_Count}, 32'd16);
        chk("full_launch_full", {31'd0, o_Full}, 32'd1);
        chk("full_launch_no_ovf", {31'd0, o_Overflow}, 32'd0);
        wait_drain(17 * 12 + 100);
        chk("full_dv_count", dv_cnt - dv0, 32'd17);

        // CR handling.
        dv0 = dv_cnt;
        i_RX_DV   = 1'b1;
        i_RX_Byte = 8'h0D;
        sb.push_back(8'h0D);
`ifdef UART_FIFO_CRLF_EN
        sb.push_back(8'h0A);
`endif
        @(negedge i_Clk);
        push_byte(8'h41, 1'b1);
        wait_drain(200);
`ifdef UART_FIFO_CRLF_EN
        chk("crlf_dv_count", dv_cnt - dv0, 32'd3);
`else
        chk("crlf_dv_count", dv_cnt - dv0, 32'd2);
`endif
        chk("crlf_count", {27'd0, o_Count}, 32'd0);

        // Reset mid-transfer: buffered bytes discarded, later done pulse ignored.
        busy_len = 50;
        for (int i = 0; i < 3; i++) push_byte(8'hB0 + 8'(i), 1'b1);
        repeat (10) @(negedge i_Clk);
        i_Rst_L = 1'b0;
        repeat (3) @(negedge i_Clk);
        sb.delete();
        dv0 = dv_cnt;
        chk("mrst_tx_dv", {31'd0, o_TX_DV}, 32'd0);
        chk("mrst_count", {27'd0, o_Count}, 32'd0);
        chk("mrst_empty", {31'd0, o_Empty}, 32'd1);
        chk("mrst_ovf", {31'd0, o_Overflow}, 32'd0);
        chk("mrst_tx_byte", {24'd0, o_TX_Byte}, 32'd0);
        i_Rst_L = 1'b1;
        repeat (100) @(negedge i_Clk);
        chk("mrst_no_dv_after", dv_cnt - dv0, 32'd0);
        chk("mrst_still_empty", {31'd0, o_Empty}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
